// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, transmitter start/data/busy handshake and lock status
// shared between the requesting blocks (master side) and uart_tx_arbiter (slave side).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 grant_valid;
    logic [IDW-1:0]       grant_id;
    logic                 timeout_err;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant_valid, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter: locks one UART transmitter to a single requester
// for a whole frame, releasing on the last byte or after an inactivity timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus_io
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     g_q, g_d;
    logic               last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               grant_valid_q, grant_valid_d;
    logic               timeout_err_q, timeout_err_d;

    logic               any_valid;
    logic [IDW-1:0]     pick;
    logic [IDW-1:0]     g_plus;
    logic               accept;
    logic [NUM_REQ-1:0] req_ready;

    // Walk from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (bus_io.req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = idx[IDW-1:0];
            end
        end
    end

    assign g_plus = (g_q == IDW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
    assign accept = (state_q == SEND) && bus_io.req_valid[g_q] && !bus_io.tx_busy;

    always_comb begin
        req_ready = '0;
        if (state_q == SEND && !bus_io.tx_busy) begin
            req_ready[g_q] = bus_io.req_valid[g_q];
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        g_d           = g_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        grant_valid_d = grant_valid_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    g_d           = pick;
                    grant_valid_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = SEND;
                end
            end

            SEND: begin
                if (accept) begin
                    tx_data_d  = bus_io.req_data[8*g_q +: 8];
                    last_d     = bus_io.req_last[g_q];
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = WAIT_BUSY;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    grant_valid_d = 1'b0;
                    ptr_d         = g_plus;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // A transmitter that never acknowledges the start would otherwise hang the lock.
            WAIT_BUSY: begin
                if (bus_io.tx_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    grant_valid_d = 1'b0;
                    ptr_d         = g_plus;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_DONE: begin
                if (!bus_io.tx_busy) begin
                    cnt_d = '0;
                    if (last_q) begin
                        grant_valid_d = 1'b0;
                        ptr_d         = g_plus;
                        state_d       = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            g_q           <= '0;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            grant_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            g_q           <= g_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            grant_valid_q <= grant_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus_io.req_ready   = req_ready;
    assign bus_io.tx_start    = tx_start_q;
    assign bus_io.tx_data     = tx_data_q;
    assign bus_io.grant_valid = grant_valid_q;
    assign bus_io.grant_id    = g_q;
    assign bus_io.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single frame, round-robin order, lock
// exclusivity, inactivity and stuck-transmitter timeouts, and reset mid-frame.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int TIMEOUT  = 16;
    localparam int BUSY_LEN = 10;

    logic clk;
    logic rst;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) arbIf ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(arbIf)
    );

    int totalCnt = 0;
    int badCnt   = 0;
    int toCount  = 0;
    int busyCnt  = 0;
    bit modelOn  = 1'b1;
    bit forceBusy = 1'b0;

    logic [9:0] txLog[$];
    logic [9:0] expQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: logs every start pulse and holds busy for BUSY_LEN cycles.
    always @(negedge clk) begin
        if (arbIf.tx_start === 1'b1) begin
            txLog.push_back({arbIf.grant_id, arbIf.tx_data});
            if (modelOn) busyCnt = BUSY_LEN;
        end else if (busyCnt > 0) begin
            busyCnt = busyCnt - 1;
        end
        arbIf.tx_busy = (busyCnt != 0) || forceBusy;
    end

    // Counts timeout pulses seen over the whole run.
    always @(negedge clk) begin
        #1;
        if (arbIf.timeout_err === 1'b1) toCount = toCount + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt = totalCnt + 1;
        if (got !== exp) begin
            badCnt = badCnt + 1;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [9:0] mkEntry(input int id, input int b);
        logic [9:0] e;
        e[9:8] = id[1:0];
        e[7:0] = b[7:0];
        return e;
    endfunction

    // Presents one byte for requester id and returns once it has been accepted.
    task automatic applyStimulus(input int id, input logic [7:0] b, input logic last, output bit ok);
        arbIf.req_data[8*id +: 8] = b;
        arbIf.req_last[id]        = last;
        arbIf.req_valid[id]       = 1'b1;
        ok = 1'b0;
        #1;
        for (int n = 0; n < 400; n++) begin
            if (arbIf.req_ready[id] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        arbIf.req_valid[id] = 1'b0;
        arbIf.req_last[id]  = 1'b0;
    endtask

    task automatic sendSingle(input int id, input logic [7:0] b);
        bit ok;
        applyStimulus(id, b, 1'b1, ok);
        checkOutput($sformatf("accept_r%0d", id), ok, 1);
    endtask

    task automatic sendAll(input string tag);
        fork
            sendSingle(0, 8'h10);
            sendSingle(1, 8'h11);
            sendSingle(2, 8'h12);
            sendSingle(3, 8'h13);
        join
    endtask

    task automatic waitIdle(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (arbIf.grant_valid === 1'b0 && arbIf.tx_busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        checkOutput(tag, done, 1);
    endtask

    task automatic checkLog(input string tag, input int base);
        checkOutput({tag, "_len"}, txLog.size() - base, expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_%0d", tag, i), txLog[base + i], expQ[i]);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, arbIf.req_ready, 0);
        checkOutput({tag, "_start"}, arbIf.tx_start, 0);
        checkOutput({tag, "_data"}, arbIf.tx_data, 0);
        checkOutput({tag, "_gv"}, arbIf.grant_valid, 0);
        checkOutput({tag, "_gid"}, arbIf.grant_id, 0);
        checkOutput({tag, "_terr"}, arbIf.timeout_err, 0);
    endtask

    initial begin
        bit ok;
        bit seen;
        bit leak;
        int base;
        int n;

        rst = 1'b1;
        arbIf.req_valid = '0;
        arbIf.req_data  = '0;
        arbIf.req_last  = '0;
        repeat (3) tick();
        checkResetOutputs("reset");
        rst = 1'b0;
        tick();

        // Single three-byte frame from requester 1.
        base = txLog.size();
        applyStimulus(1, 8'h41, 1'b0, ok);
        checkOutput("sf_acc0", ok, 1);
        applyStimulus(1, 8'h42, 1'b0, ok);
        checkOutput("sf_acc1", ok, 1);
        applyStimulus(1, 8'h43, 1'b1, ok);
        checkOutput("sf_acc2", ok, 1);
        seen = 1'b0;
        for (n = 0; n < 50; n++) begin
            if (arbIf.tx_busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("sf_busy_rise", seen, 1);
        seen = 1'b0;
        for (n = 0; n < 50; n++) begin
            if (arbIf.tx_busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("sf_busy_fall", seen, 1);
        checkOutput("sf_gv_at_fall", arbIf.grant_valid, 1);
        checkOutput("sf_gid", arbIf.grant_id, 1);
        tick();
        checkOutput("sf_gv_after_fall", arbIf.grant_valid, 0);
        expQ.delete();
        expQ.push_back(mkEntry(1, 'h41));
        expQ.push_back(mkEntry(1, 'h42));
        expQ.push_back(mkEntry(1, 'h43));
        checkLog("sf_log", base);

        // Pointer left at 2 by the frame above decides the order.
        base = txLog.size();
        sendAll("rr_ptr2");
        waitIdle("rr_ptr2_idle");
        expQ.delete();
        expQ.push_back(mkEntry(2, 'h12));
        expQ.push_back(mkEntry(3, 'h13));
        expQ.push_back(mkEntry(0, 'h10));
        expQ.push_back(mkEntry(1, 'h11));
        checkLog("rr_ptr2", base);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        expQ.delete();
        expQ.push_back(mkEntry(0, 'h10));
        expQ.push_back(mkEntry(1, 'h11));
        expQ.push_back(mkEntry(2, 'h12));
        expQ.push_back(mkEntry(3, 'h13));
        base = txLog.size();
        sendAll("rr_a");
        waitIdle("rr_a_idle");
        checkLog("rr_a", base);
        base = txLog.size();
        sendAll("rr_b");
        waitIdle("rr_b_idle");
        checkLog("rr_b", base);

        // Requester 0 joins while requester 2 holds a four-byte frame.
        base = txLog.size();
        leak = 1'b0;
        fork
            begin
                bit okA;
                applyStimulus(2, 8'hA0, 1'b0, okA);
                checkOutput("ni_acc0", okA, 1);
                applyStimulus(2, 8'hA1, 1'b0, okA);
                checkOutput("ni_acc1", okA, 1);
                applyStimulus(2, 8'hA2, 1'b0, okA);
                checkOutput("ni_acc2", okA, 1);
                applyStimulus(2, 8'hA3, 1'b1, okA);
                checkOutput("ni_acc3", okA, 1);
            end
            begin
                bit okB;
                bit grew;
                grew = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    if (txLog.size() >= base + 1) begin
                        grew = 1'b1;
                        break;
                    end
                    tick();
                end
                checkOutput("ni_first_byte", grew, 1);
                applyStimulus(0, 8'h77, 1'b1, okB);
                checkOutput("ni_acc_r0", okB, 1);
            end
            begin
                for (int k = 0; k < 600; k++) begin
                    if (txLog.size() >= base + 4) break;
                    if (arbIf.req_ready[0] === 1'b1) leak = 1'b1;
                    tick();
                end
            end
        join
        waitIdle("ni_idle");
        checkOutput("ni_ready0_leak", leak, 0);
        expQ.delete();
        expQ.push_back(mkEntry(2, 'hA0));
        expQ.push_back(mkEntry(2, 'hA1));
        expQ.push_back(mkEntry(2, 'hA2));
        expQ.push_back(mkEntry(2, 'hA3));
        expQ.push_back(mkEntry(0, 'h77));
        checkLog("ni", base);

        // Requester 3 sends a non-last byte, then goes quiet.
        applyStimulus(3, 8'h33, 1'b0, ok);
        checkOutput("to_acc", ok, 1);
        seen = 1'b0;
        for (n = 0; n < 50; n++) begin
            if (arbIf.tx_busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("to_busy_rise", seen, 1);
        seen = 1'b0;
        for (n = 0; n < 50; n++) begin
            if (arbIf.tx_busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("to_busy_fall", seen, 1);
        seen = 1'b0;
        for (n = 1; n <= 60; n++) begin
            tick();
            if (arbIf.timeout_err === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("to_pulse_seen", seen, 1);
        checkOutput("to_pulse_delay", n, 17);
        checkOutput("to_gv_released", arbIf.grant_valid, 0);
        tick();
        checkOutput("to_pulse_width", arbIf.timeout_err, 0);
        checkOutput("to_count", toCount, 1);
        base = txLog.size();
        fork
            sendSingle(0, 8'h50);
            sendSingle(3, 8'h53);
        join
        waitIdle("to_next_idle");
        expQ.delete();
        expQ.push_back(mkEntry(0, 'h50));
        expQ.push_back(mkEntry(3, 'h53));
        checkLog("to_next", base);

        // Transmitter never raises busy after the start pulse.
        modelOn = 1'b0;
        base = txLog.size();
        applyStimulus(1, 8'hAA, 1'b1, ok);
        checkOutput("st_acc", ok, 1);
        seen = 1'b0;
        for (n = 1; n <= 60; n++) begin
            tick();
            if (arbIf.timeout_err === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("st_pulse_seen", seen, 1);
        checkOutput("st_pulse_delay", n, 17);
        checkOutput("st_gv_released", arbIf.grant_valid, 0);
        expQ.delete();
        expQ.push_back(mkEntry(1, 'hAA));
        checkLog("st", base);
        modelOn = 1'b1;
        tick();
        checkOutput("st_count", toCount, 2);

        // Reset while the transmitter is still busy with a frame byte.
        applyStimulus(2, 8'hC1, 1'b0, ok);
        checkOutput("rm_acc", ok, 1);
        tick();
        forceBusy = 1'b1;
        tick();
        tick();
        checkOutput("rm_busy_before", arbIf.tx_busy, 1);
        arbIf.req_data[8*2 +: 8] = 8'hC2;
        arbIf.req_last[2]        = 1'b1;
        arbIf.req_valid[2]       = 1'b1;
        rst = 1'b1;
        #1;
        checkResetOutputs("rm");
        tick();
        rst = 1'b0;
        base = txLog.size();
        leak = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (arbIf.req_ready[2] === 1'b1 || txLog.size() != base) leak = 1'b1;
        end
        checkOutput("rm_no_start_while_busy", leak, 0);
        checkOutput("rm_gv_held", arbIf.grant_valid, 1);
        forceBusy = 1'b0;
        applyStimulus(2, 8'hC2, 1'b1, ok);
        checkOutput("rm_acc_after", ok, 1);
        waitIdle("rm_idle");
        expQ.delete();
        expQ.push_back(mkEntry(2, 'hC2));
        checkLog("rm", base);
        checkOutput("rm_no_timeout", toCount, 2);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-level round-robin arbiter that shares one UART transmitter between `NUM_REQ` requesters. Each requester streams bytes with a valid/ready handshake and marks its last byte. The arbiter locks the transmitter to one requester for a whole frame, so frames never interleave, and releases the lock on the last byte or on an inactivity timeout. It sits in the system clock domain between the requesting blocks and the transmitter's start/data/busy interface.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1024: idle cycles allowed inside a locked frame before forced release, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  byte available, one bit per requester.
- `req_data`  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- `req_last`  in  NUM_REQ  qualifies the byte as the last of its frame.
- `req_ready`  out  NUM_REQ  byte accepted this cycle (combinational).
- `tx_start`  out  1  one-cycle start pulse to the transmitter (registered).
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until the next accept (registered).
- `tx_busy`  in  1  transmitter is sending a frame (start, data, or stop bit).
- `grant_valid`  out  1  a requester currently holds the lock.
- `grant_id`  out  $clog2(NUM_REQ)  index of the lock holder; valid when `grant_valid`=1.
- `timeout_err`  out  1  one-cycle pulse when a lock is released by timeout.

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- Internal registers: `ptr` (round-robin pointer, reset 0), `g` (granted index), `last_q` (last flag of the byte in flight), and idle counter `cnt`.
- **IDLE**
  - If any `req_valid` is set, grant the first set bit found by searching `ptr`, `ptr+1`, … with wrap-around.
  - `g` ← that index, `grant_valid` ← 1, `cnt` ← 0, go to SEND.
  - If no `req_valid` is set, stay in IDLE.
- **SEND**
  - `req_ready[g]` = `req_valid[g] & ~tx_busy`. No other `req_ready` bit is ever 1.
  - On accept: `tx_data` ← that requester's byte, `last_q` ← `req_last[g]`, `tx_start` ← 1 for the next cycle, go to WAIT_BUSY.
  - Otherwise `cnt` increments. When `cnt` reaches `TIMEOUT-1`:
    - pulse `timeout_err`;
    - release the lock (`grant_valid` ← 0, `ptr` ← `g+1` mod `NUM_REQ`);
    - go to IDLE.
- **WAIT_BUSY**
  - Wait for `tx_busy`=1, then go to WAIT_DONE.
  - If `tx_busy` stays 0 for `TIMEOUT` cycles, pulse `timeout_err`, release the lock, and go to IDLE.
- **WAIT_DONE**
  - Wait for `tx_busy`=0.
  - If `last_q`=1: release the lock, `ptr` ← `g+1` mod `NUM_REQ`, go to IDLE.
  - If `last_q`=0: `cnt` ← 0, go to SEND. The lock is kept.
- **Lock rules**
  - Requests from other requesters during a lock are ignored; they remain pending.
  - A requester dropping `req_valid` mid-frame is legal until the timeout expires.
- **Reset values**
  - All outputs are 0: `req_ready`, `tx_start`, `tx_data`=8'h00, `grant_valid`, `grant_id`, `timeout_err`.
  - State IDLE, `ptr`=0, `cnt`=0.
- **Reset mid-operation**
  - The frame is abandoned immediately with no `timeout_err` pulse.
  - If the transmitter is still busy, SEND does not accept a byte until `tx_busy`=0.

## Timing
- Arbitration latency: request seen in IDLE at cycle N → state SEND at N+1. `req_ready` can be high in N+1 if `tx_busy`=0.
- Accept at cycle M → `tx_start`=1 and the new `tx_data` at M+1, exactly one cycle.
- Back-to-back bytes are never overlapped. Each byte waits for the `tx_busy` rise and then its fall.
- Minimum gap from `tx_busy` fall to the next `tx_start` within a frame is 2 cycles: WAIT_DONE→SEND, then accept.
- `grant_valid` and `grant_id` change only on the clock edge that enters or leaves a lock.
- Simultaneous cases:
  - Several requesters valid in IDLE: the pointer order decides the grant.
  - `req_last` and a timeout in the same cycle cannot occur, because an accept resets the SEND path.
  - `tx_busy` falls in the same cycle a new request arrives: the lock holder keeps priority while locked.

## Test plan
- **Single frame.** Reset; requester 1 sends 3 bytes 0x41, 0x42, 0x43 with `req_last` on the third; transmitter model holds `busy` for 10 cycles per byte.
  - Expect 3 `tx_start` pulses carrying those bytes in order.
  - `grant_id`=1 throughout; `grant_valid` falls after the third `busy` fall; `ptr`=2.
- **Round-robin order.** All 4 requesters send one single-byte frame each (0x10+i) at cycle 0.
  - Transmit order is 0, 1, 2, 3.
  - A repeat of the same stimulus gives the same order, because `ptr` has wrapped to 0.
- **No interleaving.** Requester 2 is locked on a 4-byte frame; requester 0 asserts valid after byte 1.
  - Requester 0's byte is sent only after requester 2's last byte.
  - `req_ready[0]` stays 0 during the lock.
- **Inactivity timeout.** `TIMEOUT`=16; requester 3 sends one non-last byte, then drops `req_valid`.
  - `timeout_err` pulses once 16 cycles after re-entering SEND.
  - `grant_valid`→0; the next grant search starts at index 0.
- **Stuck transmitter.** `tx_busy` never rises after `tx_start`.
  - `timeout_err` pulses after `TIMEOUT` cycles; the lock is released.
- **Reset mid-frame.** Assert `rst` during WAIT_DONE with `tx_busy`=1.
  - All outputs go to 0 immediately.
  - After release, no `tx_start` occurs until `tx_busy` falls.
